// File: rtl/fpga_imem_loader.sv
// Caliptra instruction memory (single-port BRAM) with a narrow loader port.
// Narrow loader writes are merged into wide words by read-modify-write; the core read port always wins arbitration.
module fpga_imem_loader #(
    parameter  int IMEM_DATA_W = 64,
    parameter  int IMEM_ADDR_W = 13,
    parameter  int LOAD_DATA_W = 32,
    localparam int LOAD_ADDR_W = IMEM_ADDR_W + $clog2(IMEM_DATA_W / LOAD_DATA_W)
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic                     imem_cs,
    input  logic [IMEM_ADDR_W-1:0]   imem_addr,
    output logic [IMEM_DATA_W-1:0]   imem_rdata,
    input  logic                     ld_valid,
    input  logic                     ld_we,
    input  logic [LOAD_ADDR_W-1:0]   ld_addr,
    input  logic [LOAD_DATA_W-1:0]   ld_wdata,
    input  logic [LOAD_DATA_W/8-1:0] ld_strb,
    output logic                     ld_ready,
    output logic                     ld_rvalid,
    output logic [LOAD_DATA_W-1:0]   ld_rdata,
    input  logic                     lock,
    input  logic                     checksum_clr,
    output logic                     ld_err,
    output logic [31:0]              ld_checksum,
    output logic [15:0]              ld_wr_count
);

    localparam int RATIO   = IMEM_DATA_W / LOAD_DATA_W;
    localparam int LANE_W  = $clog2(RATIO);
    localparam int LANE_IW = (LANE_W > 0) ? LANE_W : 1;
    localparam int STRB_W  = LOAD_DATA_W / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MERGE = 2'd1;
    localparam logic [1:0] WR    = 2'd2;

    logic [1:0]             state;
    logic [IMEM_DATA_W-1:0] mem [2**IMEM_ADDR_W];
    logic [IMEM_DATA_W-1:0] rdata_q;
    logic [IMEM_DATA_W-1:0] merged_q;
    logic [IMEM_DATA_W-1:0] merge_word;
    logic [IMEM_ADDR_W-1:0] word_addr;
    logic [IMEM_ADDR_W-1:0] mem_addr;
    logic [LANE_IW-1:0]     lane;
    logic [LOAD_DATA_W-1:0] lane_data;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   locked_wr;
    logic                   wr_done;
    logic [31:0]            contrib;

    function automatic logic [LOAD_DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] s);
        logic [LOAD_DATA_W-1:0] m;
        m = {LOAD_DATA_W{1'b0}};
        for (int b = 0; b < STRB_W; b++) begin
            m[8*b +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

    assign word_addr = ld_addr[LOAD_ADDR_W-1:LANE_W];

    generate
        if (LANE_W > 0) begin : g_lane
            assign lane = ld_addr[LANE_IW-1:0];
        end else begin : g_single_lane
            assign lane = 1'b0;
        end
    endgenerate

    assign lane_data = LOAD_DATA_W'(rdata_q >> (LOAD_DATA_W * int'(lane)));
    assign locked_wr = (state == IDLE) && ld_valid && ld_we && lock;
    assign wr_done   = (state == WR) && !imem_cs;
    assign contrib   = 32'(ld_wdata & strb_mask(ld_strb));

    assign ld_ready   = locked_wr || ((state == MERGE) && !ld_we) || wr_done;
    assign ld_rvalid  = (state == MERGE) && !ld_we;
    assign ld_rdata   = ld_rvalid ? lane_data : {LOAD_DATA_W{1'b0}};
    assign imem_rdata = rdata_q;

    // Single memory port: core read, then loader read from IDLE, then the pending merged write
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = imem_addr;
        if (imem_cs) begin
            mem_rd = 1'b1;
        end else if ((state == IDLE) && ld_valid && !(ld_we && lock)) begin
            mem_rd   = 1'b1;
            mem_addr = word_addr;
        end else if (state == WR) begin
            mem_wr   = 1'b1;
            mem_addr = word_addr;
        end else begin
            mem_rd = 1'b0;
        end
    end

    // Strobed bytes of the addressed lane replace the bytes of the word read back
    always_comb begin
        merge_word = rdata_q;
        for (int i = 0; i < IMEM_DATA_W / 8; i++) begin
            if ((LANE_IW'(i / STRB_W) == lane) && ld_strb[i % STRB_W]) begin
                merge_word[8*i +: 8] = ld_wdata[8*(i % STRB_W) +: 8];
            end else begin
                merge_word[8*i +: 8] = rdata_q[8*i +: 8];
            end
        end
    end

    // Loader sequencing
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= (ld_valid && !locked_wr && !imem_cs) ? MERGE : IDLE;
                MERGE:   state <= ld_we ? WR : IDLE;
                WR:      state <= imem_cs ? WR : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Merged word is captured once and held while the core keeps the port busy
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            merged_q <= {IMEM_DATA_W{1'b0}};
        end else if ((state == MERGE) && ld_we) begin
            merged_q <= merge_word;
        end else begin
            merged_q <= merged_q;
        end
    end

    // Memory array is deliberately not reset so contents survive rst
    always_ff @(posedge core_clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= merged_q;
        end
    end

    // Shared read register for core and loader reads
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {IMEM_DATA_W{1'b0}};
        end else if (mem_rd) begin
            rdata_q <= mem[mem_addr];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    // Error flag, checksum and write counter; a clear lands before a same-cycle completion
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            ld_err      <= 1'b0;
            ld_checksum <= 32'd0;
            ld_wr_count <= 16'd0;
        end else begin
            if (locked_wr) begin
                ld_err <= 1'b1;
            end else if (checksum_clr) begin
                ld_err <= 1'b0;
            end else begin
                ld_err <= ld_err;
            end
            if (checksum_clr) begin
                ld_checksum <= wr_done ? contrib : 32'd0;
                ld_wr_count <= wr_done ? 16'd1 : 16'd0;
            end else if (wr_done) begin
                ld_checksum <= ld_checksum + contrib;
                ld_wr_count <= (ld_wr_count == 16'hFFFF) ? ld_wr_count : ld_wr_count + 16'd1;
            end else begin
                ld_checksum <= ld_checksum;
                ld_wr_count <= ld_wr_count;
            end
        end
    end

endmodule

// File: tb/tb_fpga_imem_loader.sv
// Scoreboard bench for fpga_imem_loader: byte-level memory model, expected responses queued at issue,
// a negedge monitor pops and compares on every core read result and loader completion.
module tb_fpga_imem_loader;
    localparam int IAW = 13;
    localparam int LAW = 14;

    logic        core_clk;
    logic        rst;
    logic        imem_cs;
    logic [12:0] imem_addr;
    logic [63:0] imem_rdata;
    logic        ld_valid;
    logic        ld_we;
    logic [13:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_strb;
    logic        ld_ready;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        lock;
    logic        checksum_clr;
    logic        ld_err;
    logic [31:0] ld_checksum;
    logic [15:0] ld_wr_count;

    fpga_imem_loader dut (
        .core_clk(core_clk), .rst(rst),
        .imem_cs(imem_cs), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_strb(ld_strb), .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .lock(lock), .checksum_clr(checksum_clr), .ld_err(ld_err),
        .ld_checksum(ld_checksum), .ld_wr_count(ld_wr_count)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
        int          lat;
    } ld_exp_t;

    ld_exp_t     ld_q[$];
    logic [63:0] core_q[$];
    logic [7:0]  mb[int];
    logic [31:0] sum_m;
    logic [15:0] cnt_m;
    logic        err_m;
    int          checks;
    int          passes;
    bit          rand_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: got no/unexpected response, expected a matching one", name);
    endtask

    function automatic logic [63:0] word_m(input int w);
        logic [63:0] v;
        v = 64'h0;
        for (int b = 0; b < 8; b++) if (mb.exists(w*8 + b)) v[8*b +: 8] = mb[w*8 + b];
        return v;
    endfunction

    function automatic logic [31:0] lane_m(input int la);
        logic [31:0] v;
        v = 32'h0;
        for (int b = 0; b < 4; b++) if (mb.exists(la*4 + b)) v[8*b +: 8] = mb[la*4 + b];
        return v;
    endfunction

    task automatic model_write(input int la, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                mb[la*4 + b] = d[8*b +: 8];
                sum_m = sum_m + ({24'h0, d[8*b +: 8]} << (8*b));
            end
        end
        cnt_m = (cnt_m == 16'hFFFF) ? cnt_m : cnt_m + 16'd1;
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive_rand_cs();
        imem_cs   = ($urandom_range(2) == 0);
        imem_addr = IAW'($urandom_range(7));
        if (imem_cs) core_q.push_back(word_m(int'(imem_addr)));
    endtask

    task automatic core_rd(input int w);
        imem_cs   = 1'b1;
        imem_addr = IAW'(w);
        core_q.push_back(word_m(w));
        tick();
        imem_cs = 1'b0;
    endtask

    task automatic ld_op(input bit we, input int la, input logic [31:0] d, input logic [3:0] s, input int lat);
        ld_exp_t e;
        bit got;
        bit locked;
        locked  = we && lock;
        e.is_rd = !we;
        e.data  = we ? 32'h0 : lane_m(la);
        e.lat   = lat;
        ld_q.push_back(e);
        ld_valid = 1'b1; ld_we = we; ld_addr = LAW'(la); ld_wdata = d; ld_strb = s;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (rand_cs) drive_rand_cs();
            @(negedge core_clk);
            if (ld_ready) got = 1'b1;
            else tick();
        end
        if (!got) fail("ld_timeout");
        else if (locked) err_m = 1'b1;
        else if (we) model_write(la, d, s);
        else err_m = err_m;
        tick();
        ld_valid = 1'b0;
        imem_cs  = 1'b0;
    endtask

    // Monitor: compares every core read result and every loader completion against the queues
    bit      core_pend;
    int      lat_cnt;
    ld_exp_t mon_e;
    always @(negedge core_clk) begin
        if (rst) begin
            core_pend = 1'b0;
            lat_cnt   = 0;
        end else begin
            if (core_pend) begin
                if (core_q.size() == 0) fail("core_q_empty");
                else check("imem_rdata", imem_rdata, core_q.pop_front());
            end
            core_pend = imem_cs;
            if (ld_ready) begin
                if (ld_q.size() == 0) begin
                    fail("unexpected_ld_ready");
                end else begin
                    mon_e = ld_q.pop_front();
                    check("ld_rvalid", 64'(ld_rvalid), 64'(mon_e.is_rd));
                    if (mon_e.is_rd) check("ld_rdata", 64'(ld_rdata), 64'(mon_e.data));
                    if (mon_e.lat >= 0) check("ld_latency", 64'(lat_cnt), 64'(mon_e.lat));
                end
                lat_cnt = 0;
            end else if (ld_valid) begin
                lat_cnt++;
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_rdata"}, imem_rdata, 64'h0);
        check({tag, "_ld_ready"}, 64'(ld_ready), 64'h0);
        check({tag, "_ld_rvalid"}, 64'(ld_rvalid), 64'h0);
        check({tag, "_ld_rdata"}, 64'(ld_rdata), 64'h0);
        check({tag, "_ld_err"}, 64'(ld_err), 64'h0);
        check({tag, "_ld_checksum"}, 64'(ld_checksum), 64'h0);
        check({tag, "_ld_wr_count"}, 64'(ld_wr_count), 64'h0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_checksum"}, 64'(ld_checksum), 64'(sum_m));
        check({tag, "_count"}, 64'(ld_wr_count), 64'(cnt_m));
        check({tag, "_err"}, 64'(ld_err), 64'(err_m));
    endtask

    initial begin
        ld_exp_t e;
        int  rdy_seen;
        int  c_rel;
        bit  got;
        int  k;
        checks = 0; passes = 0; sum_m = 32'h0; cnt_m = 16'h0; err_m = 1'b0; rand_cs = 1'b0;
        rst = 1'b1; imem_cs = 1'b0; imem_addr = '0; ld_valid = 1'b0; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = 32'h0; ld_strb = 4'h0; lock = 1'b0; checksum_clr = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic writes, partial-strobe merge, loader readback
        ld_op(1'b1, 0, 32'hDEADBEEF, 4'hF, 2);
        ld_op(1'b1, 1, 32'h01234567, 4'hF, 2);
        core_rd(0);
        check_counters("two_writes");
        ld_op(1'b1, 0, 32'hAABBCCDD, 4'h3, 2);
        core_rd(0);
        check_counters("strobed_write");
        ld_op(1'b0, 1, 32'h0, 4'h0, 1);

        // Core holds the port for six cycles during a loader write
        imem_cs = 1'b1; imem_addr = '0;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_wdata = 32'h55667788; ld_strb = 4'hF;
        e.is_rd = 1'b0; e.data = 32'h0; e.lat = -1;
        ld_q.push_back(e);
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            core_q.push_back(word_m(0));
            @(negedge core_clk);
            if (ld_ready) rdy_seen++;
            tick();
        end
        imem_cs = 1'b0;
        check("no_ready_under_cs", 64'(rdy_seen), 64'h0);
        got = 1'b0; c_rel = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge core_clk);
            if (ld_ready) begin got = 1'b1; c_rel = c; end
            else tick();
        end
        if (!got) fail("ready_after_release");
        else begin
            check("ready_after_release_le2", 64'(c_rel <= 2), 64'h1);
            model_write(0, 32'h55667788, 4'hF);
        end
        tick();
        ld_valid = 1'b0;
        core_rd(0);

        // Locked write is refused but reads still work
        lock = 1'b1;
        ld_op(1'b1, 0, 32'hFFFFFFFF, 4'hF, 0);
        check_counters("locked");
        core_rd(0);
        ld_op(1'b0, 0, 32'h0, 4'h0, 1);
        lock = 1'b0;

        // Clear coincident with a write completion
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = LAW'(2); ld_wdata = 32'h00000010; ld_strb = 4'hF;
        e.is_rd = 1'b0; e.data = 32'h0; e.lat = 2;
        ld_q.push_back(e);
        tick(); tick();
        checksum_clr = 1'b1;
        @(negedge core_clk);
        check("clr_cycle_ready", 64'(ld_ready), 64'h1);
        sum_m = 32'h0; cnt_m = 16'h0; err_m = 1'b0;
        model_write(2, 32'h00000010, 4'hF);
        tick();
        checksum_clr = 1'b0; ld_valid = 1'b0;
        check_counters("clr_with_write");

        // Reset while the FSM sits in WR: write aborted, contents retained
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_wdata = 32'h99999999; ld_strb = 4'hF;
        tick(); tick();
        rst = 1'b1; ld_valid = 1'b0;
        #1;
        check_all_zero("mid_rmw_reset");
        tick();
        rst = 1'b0; sum_m = 32'h0; cnt_m = 16'h0; err_m = 1'b0;
        tick();
        core_rd(0);
        ld_op(1'b0, 0, 32'h0, 4'h0, 1);
        check_counters("after_reset");

        // Randomized traffic with random core contention and occasional lock
        for (int w = 0; w < 8; w++) begin
            ld_op(1'b1, 2*w, $urandom, 4'hF, 2);
            ld_op(1'b1, 2*w + 1, $urandom, 4'hF, 2);
        end
        rand_cs = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(3));
            lock = ($urandom_range(5) == 0);
            case (k)
                0, 1:    ld_op(1'b1, int'($urandom_range(15)), $urandom, 4'($urandom_range(15)), -1);
                2:       ld_op(1'b0, int'($urandom_range(15)), 32'h0, 4'h0, -1);
                default: core_rd(int'($urandom_range(7)));
            endcase
        end
        rand_cs = 1'b0; lock = 1'b0;
        for (int w = 0; w < 8; w++) core_rd(w);
        tick(); tick();
        check_counters("random_end");
        check("ld_q_drained", 64'(ld_q.size()), 64'h0);
        check("core_q_drained", 64'(core_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
